port_irq_controller: RTL and testbench
======================================

Name: port_irq_controller

Overview:
Parametrised interrupt controller that sits on the peripheral port bus and collects the per-port interrupt lines into a single processor interrupt.
- Replaces the flat `interupt[31:0]` wiring with per-source latching, masking, edge/level mode selection and fixed priority.
- Provides an acknowledge / end-of-interrupt handshake so the processor services one source at a time.
- Occupies one port address; its internal registers are selected by `regSel`.

Parameters:
- NUM_SRC, 32, number of interrupt sources (1..32); source 0 has the highest priority.
- ID_W, 5, width of the source id; must satisfy 2^ID_W >= NUM_SRC.

Ports:
- clkCPU  in  1  processor clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- irqIn  in  NUM_SRC  raw interrupt lines from the port modules.
- read  in  1  port read strobe, already address-decoded.
- write  in  1  port write strobe, already address-decoded.
- regSel  in  3  register select.
- dataIn  in  32  write data.
- dataOut  out  32  registered read data.
- dataOutValid  out  1  high for exactly the one cycle in which dataOut is valid.
- cpuIrq  out  1  interrupt request to the processor.
- irqVector  out  ID_W  id of the source being requested or in service.
- irqAck  in  1  one-cycle acknowledge pulse from the processor.

Behaviour:
- Reset (synchronous): pending=0, mask=0, mode=all-ones (edge), prevIn=0, inService=0, state=IDLE; dataOut=0, dataOutValid=0, cpuIrq=0, irqVector=0.
- Register map (bits above NUM_SRC read 0 and ignore writes):
  - 0 PENDING: R; write-1-to-clear, edge sources only.
  - 1 MASK: R/W; 1 = enabled.
  - 2 MODE: R/W; 1 = edge, 0 = level.
  - 3 STATUS: R = {state[1:0] in bits 31:30, zeros, irqVector in the low ID_W bits}.
  - 4 EOI: W; any write ends service.
  - 5..7: reserved; read 0, writes ignored.
- Reads:
  - dataOut and dataOutValid update one cycle after `read`.
  - Read data reflects register contents before any same-cycle write.
  - Back-to-back reads are supported, one result per cycle.
- Source latching, per bit i, every cycle:
  - Edge mode: pending[i] is set on `irqIn[i] & ~prevIn[i]`; prevIn is updated every cycle. A set and a W1C clear in the same cycle: the set wins.
  - Level mode: pending[i] = irqIn[i], registered; W1C has no effect.
  - Changing a bit from level to edge clears that pending bit; edge to level needs no action.
- Requests: eligible = pending & mask. A fixed-priority encoder picks the lowest eligible index as winner.
- State machine:
  - IDLE: if eligible != 0, latch the winner into irqVector, set cpuIrq=1, go to REQ (one-cycle latency from pending to cpuIrq).
  - REQ:
    - irqVector re-arbitrates each cycle, so a higher-priority arrival preempts before acknowledge.
    - If eligible becomes 0 (masked or cleared), drop cpuIrq and return to IDLE.
    - On irqAck: set inService to irqVector, clear pending[irqVector] if that source is in edge mode, drop cpuIrq next cycle, go to SERVICE.
    - An edge on the same source in the ack cycle leaves pending set.
  - SERVICE:
    - cpuIrq=0; irqVector holds the in-service id; no nesting.
    - A write to EOI returns to IDLE; the next request can assert cpuIrq in the following cycle.
    - A level source still high after EOI re-requests immediately.
  - irqAck outside REQ is ignored. EOI outside SERVICE is ignored.
- If irqAck and the drop of eligibility occur in the same cycle, the ack takes effect.
- reset asserted in any state returns to IDLE on the next edge and discards pending and inService.

Test Plan:
1. Reset, then mask=0x0000_0003, pulse irqIn[1] for one cycle -> PENDING reads 0x2, cpuIrq=1 the cycle after the pending set, irqVector=1; irqAck -> cpuIrq=0, PENDING=0, STATUS[31:30]=SERVICE; EOI write -> IDLE.
2. Priority: with mask=0xFF, edges on sources 5 and 2 in the same cycle -> irqVector=2. Ack and EOI -> irqVector=5 and cpuIrq re-asserts in the cycle after EOI.
3. Level mode on source 4 (MODE bit4=0, mask bit4=1), irqIn[4] held high -> ack, then EOI -> cpuIrq re-asserts. Drop irqIn[4] -> PENDING bit4=0 one cycle later and cpuIrq falls.
4. Edge on source 3 in the same cycle as a W1C of 0x8 -> PENDING bit3 stays 1. Edge on source 3 during its ack cycle -> bit3 remains pending after ack.
5. In REQ on source 6, clear MASK bit6 -> cpuIrq=0 and state=IDLE; PENDING bit6 still 1. Re-enable the mask -> request returns.
6. NUM_SRC=8: write 0xFFFF_FFFF to MASK -> reads 0x0000_00FF. Reset asserted mid-SERVICE -> all registers return to reset values; a read of reg 7 returns 0 with dataOutValid=1.

Source files
------------

// File: rtl/port_irq_controller.sv
// Peripheral-port interrupt controller: latches per-source requests, masks them,
// picks the lowest-index winner and runs a request/ack/EOI handshake with the CPU.
module port_irq_controller #(
  parameter int unsigned NUM_SRC = 32,
  parameter int unsigned ID_W    = 5
) (
  input  logic               clkCPU,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irqIn,
  input  logic               read,
  input  logic               write,
  input  logic [2:0]         regSel,
  input  logic [31:0]        dataIn,
  output logic [31:0]        dataOut,
  output logic               dataOutValid,
  output logic               cpuIrq,
  output logic [ID_W-1:0]    irqVector,
  input  logic               irqAck
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [2:0] SEL_PEND   = 3'd0;
  localparam logic [2:0] SEL_MASK   = 3'd1;
  localparam logic [2:0] SEL_MODE   = 3'd2;
  localparam logic [2:0] SEL_STATUS = 3'd3;
  localparam logic [2:0] SEL_EOI    = 3'd4;

  state_t               r_state, w_state_nxt;
  logic                 r_cpuIrq, w_cpuIrq_nxt;
  logic [ID_W-1:0]      r_irqVector, w_vec_nxt;
  logic [ID_W-1:0]      r_inService, w_inService_nxt;
  logic [NUM_SRC-1:0]   r_pending, r_mask, r_mode, r_prev;
  logic [31:0]          r_dataOut;
  logic                 r_dataOutValid;

  logic [NUM_SRC-1:0]   w_din, w_eligible, w_w1c, w_ack_clr, w_l2e;
  logic [NUM_SRC-1:0]   w_edge_nxt, w_pend_nxt;
  logic [ID_W-1:0]      w_winner;
  logic                 w_any, w_ack_take;
  logic                 w_wr_pend, w_wr_mask, w_wr_mode, w_wr_eoi;
  logic [31:0]          w_rdata;

  assign w_din     = dataIn[NUM_SRC-1:0];
  assign w_wr_pend = write && (regSel == SEL_PEND);
  assign w_wr_mask = write && (regSel == SEL_MASK);
  assign w_wr_mode = write && (regSel == SEL_MODE);
  assign w_wr_eoi  = write && (regSel == SEL_EOI);

  assign w_eligible = r_pending & r_mask;

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_eligible[i] && !w_any) begin
        w_winner = ID_W'(i);
        w_any    = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cpuIrq_nxt    = r_cpuIrq;
    w_vec_nxt       = r_irqVector;
    w_inService_nxt = r_inService;
    w_ack_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt  = ST_REQ;
          w_cpuIrq_nxt = 1'b1;
          w_vec_nxt    = w_winner;
        end
      end
      ST_REQ: begin
        // Ack takes priority over a same-cycle loss of eligibility.
        if (irqAck) begin
          w_ack_take      = 1'b1;
          w_inService_nxt = r_irqVector;
          w_cpuIrq_nxt    = 1'b0;
          w_state_nxt     = ST_SERVICE;
        end else if (!w_any) begin
          w_cpuIrq_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_vec_nxt = w_winner;
        end
      end
      ST_SERVICE: begin
        w_cpuIrq_nxt = 1'b0;
        w_vec_nxt    = r_inService;
        if (w_wr_eoi) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_cpuIrq_nxt = 1'b0;
      end
    endcase
  end

  // Edge sources: a new rising edge beats any same-cycle clear.
  assign w_w1c      = w_wr_pend ? w_din : '0;
  assign w_ack_clr  = w_ack_take ? (NUM_SRC'(1) << r_irqVector) : '0;
  assign w_l2e      = w_wr_mode ? (w_din & ~r_mode) : '0;
  assign w_edge_nxt = (irqIn & ~r_prev) | (r_pending & ~(w_w1c | w_ack_clr));
  assign w_pend_nxt = ((r_mode & w_edge_nxt) | (~r_mode & irqIn)) & ~w_l2e;

  always_comb begin
    w_rdata = '0;
    case (regSel)
      SEL_PEND:   w_rdata = 32'(r_pending);
      SEL_MASK:   w_rdata = 32'(r_mask);
      SEL_MODE:   w_rdata = 32'(r_mode);
      SEL_STATUS: begin
        w_rdata[31:30]     = r_state;
        w_rdata[ID_W-1:0]  = r_irqVector;
      end
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clkCPU) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cpuIrq    <= 1'b0;
      r_irqVector <= '0;
      r_inService <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpuIrq    <= w_cpuIrq_nxt;
      r_irqVector <= w_vec_nxt;
      r_inService <= w_inService_nxt;
    end
  end

  always_ff @(posedge clkCPU) begin
    if (reset) begin
      r_pending      <= '0;
      r_mask         <= '0;
      r_mode         <= '1;
      r_prev         <= '0;
      r_dataOut      <= '0;
      r_dataOutValid <= 1'b0;
    end else begin
      r_pending      <= w_pend_nxt;
      r_prev         <= irqIn;
      r_dataOutValid <= read;
      if (read)      r_dataOut <= w_rdata;
      if (w_wr_mask) r_mask    <= w_din;
      if (w_wr_mode) r_mode    <= w_din;
    end
  end

  assign dataOut      = r_dataOut;
  assign dataOutValid = r_dataOutValid;
  assign cpuIrq       = r_cpuIrq;
  assign irqVector    = r_irqVector;

endmodule

// File: tb/tb_port_irq_controller.sv
// Scoreboard bench: a per-source reference model predicts each cycle's outputs and
// read data; a monitor compares them against the DUT. A small 8-source instance is checked directly.
module tb_port_irq_controller;

  logic        clkCPU;
  logic        reset, read, write, irqAck;
  logic [31:0] irqIn, dataIn, dataOut;
  logic [2:0]  regSel;
  logic        dataOutValid, cpuIrq;
  logic [4:0]  irqVector;

  logic        b_reset, b_read, b_write, b_irqAck;
  logic [7:0]  b_irqIn;
  logic [2:0]  b_regSel;
  logic [31:0] b_dataIn, b_dataOut;
  logic        b_valid, b_cpuIrq;
  logic [2:0]  b_vec;

  port_irq_controller #(.NUM_SRC(32), .ID_W(5)) u_dut (
    .clkCPU(clkCPU), .reset(reset), .irqIn(irqIn), .read(read), .write(write),
    .regSel(regSel), .dataIn(dataIn), .dataOut(dataOut), .dataOutValid(dataOutValid),
    .cpuIrq(cpuIrq), .irqVector(irqVector), .irqAck(irqAck)
  );

  port_irq_controller #(.NUM_SRC(8), .ID_W(3)) u_dut8 (
    .clkCPU(clkCPU), .reset(b_reset), .irqIn(b_irqIn), .read(b_read), .write(b_write),
    .regSel(b_regSel), .dataIn(b_dataIn), .dataOut(b_dataOut), .dataOutValid(b_valid),
    .cpuIrq(b_cpuIrq), .irqVector(b_vec), .irqAck(b_irqAck)
  );

  initial begin
    clkCPU = 1'b0;
    forever #5 clkCPU = ~clkCPU;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit cpuirq;
    int vec;
    bit valid;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] rd_q[$];

  // Reference model: state 0=idle, 1=requesting, 2=in service.
  bit [31:0] m_pend, m_mask, m_mode, m_prev;
  int        m_state, m_vec, m_insvc;
  bit        m_cpuirq;

  function automatic void model_step();
    cyc_t      e;
    bit [31:0] elig, np, rdv;
    int        win;
    bit        ackt, rise, clr;
    e.valid = 1'b0;
    if (reset) begin
      m_pend = '0; m_mask = '0; m_mode = '1; m_prev = '0;
      m_state = 0; m_vec = 0; m_insvc = 0; m_cpuirq = 1'b0;
    end else begin
      e.valid = read;
      if (read) begin
        case (regSel)
          3'd0: rdv = m_pend;
          3'd1: rdv = m_mask;
          3'd2: rdv = m_mode;
          3'd3: rdv = (32'(m_state) << 30) | 32'(m_vec);
          default: rdv = 32'd0;
        endcase
        rd_q.push_back(rdv);
      end
      elig = m_pend & m_mask;
      win = -1;
      for (int i = 31; i >= 0; i--) if (elig[i]) win = i;
      ackt = (m_state == 1) && irqAck;
      for (int i = 0; i < 32; i++) begin
        if (m_mode[i]) begin
          rise = irqIn[i] && !m_prev[i];
          clr  = (write && regSel == 3'd0 && dataIn[i]) || (ackt && i == m_vec);
          np[i] = rise || (m_pend[i] && !clr);
        end else begin
          np[i] = irqIn[i];
        end
        if (write && regSel == 3'd2 && dataIn[i] && !m_mode[i]) np[i] = 1'b0;
      end
      case (m_state)
        0: if (win >= 0) begin m_state = 1; m_cpuirq = 1'b1; m_vec = win; end
        1: begin
          if (irqAck) begin m_insvc = m_vec; m_cpuirq = 1'b0; m_state = 2; end
          else if (win < 0) begin m_cpuirq = 1'b0; m_state = 0; end
          else m_vec = win;
        end
        default: begin
          m_cpuirq = 1'b0;
          m_vec = m_insvc;
          if (write && regSel == 3'd4) m_state = 0;
        end
      endcase
      if (write && regSel == 3'd1) m_mask = dataIn;
      if (write && regSel == 3'd2) m_mode = dataIn;
      m_prev = irqIn;
      m_pend = np;
    end
    e.cpuirq = m_cpuirq;
    e.vec    = m_vec;
    cyc_q.push_back(e);
  endfunction

  // Monitor: one expectation per clock, plus read data whenever a read was issued.
  initial begin
    cyc_t        e;
    logic [31:0] exp_d;
    forever begin
      @(posedge clkCPU);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        checks++;
        if (cpuIrq !== e.cpuirq) begin
          errors++;
          $display("FAIL cpuIrq @%0t: got %0b expected %0b", $time, cpuIrq, e.cpuirq);
        end
        checks++;
        if ({27'd0, irqVector} !== 32'(e.vec)) begin
          errors++;
          $display("FAIL irqVector @%0t: got %0d expected %0d", $time, irqVector, e.vec);
        end
        checks++;
        if (dataOutValid !== e.valid) begin
          errors++;
          $display("FAIL dataOutValid @%0t: got %0b expected %0b", $time, dataOutValid, e.valid);
        end
        if (e.valid) begin
          exp_d = rd_q.pop_front();
          checks++;
          if (dataOut !== exp_d) begin
            errors++;
            $display("FAIL dataOut @%0t: got %08h expected %08h", $time, dataOut, exp_d);
          end
        end
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clkCPU);
    @(negedge clkCPU);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] s, input logic [31:0] d);
    write = 1'b1; regSel = s; dataIn = d;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] s);
    read = 1'b1; regSel = s;
    tick();
    read = 1'b0;
  endtask

  task automatic ack();
    irqAck = 1'b1;
    tick();
    irqAck = 1'b0;
  endtask

  task automatic b_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic b_rd(input logic [2:0] s, input logic [31:0] exp, input string name);
    b_read = 1'b1; b_regSel = s;
    tick();
    b_read = 1'b0;
    b_chk({name, "_valid"}, 32'(b_valid), 32'd1);
    b_chk(name, b_dataOut, exp);
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; irqAck = 1'b0;
    irqIn = '0; dataIn = '0; regSel = '0;
    b_reset = 1'b1; b_read = 1'b0; b_write = 1'b0; b_irqAck = 1'b0;
    b_irqIn = '0; b_dataIn = '0; b_regSel = '0;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Basic request / ack / EOI on source 1
    wr(3'd1, 32'h0000_0003);
    irqIn = 32'h2; tick(); irqIn = '0; tick();
    rd(3'd0); idle(1);
    ack(); rd(3'd0); rd(3'd3);
    wr(3'd4, 32'd0); idle(2);

    // Simultaneous edges on 5 and 2
    wr(3'd1, 32'h0000_00FF);
    irqIn = 32'h24; tick(); irqIn = '0; idle(2);
    ack(); wr(3'd4, 32'd0); idle(2);
    rd(3'd3); ack(); wr(3'd4, 32'd0); idle(2);

    // Level source 4 held high, re-request after EOI, then drop
    wr(3'd2, ~32'h10);
    irqIn = 32'h10; idle(3);
    ack(); idle(1); wr(3'd4, 32'd0); idle(2);
    irqIn = '0; idle(3); rd(3'd0);
    wr(3'd2, 32'hFFFF_FFFF); idle(2);

    // Edge vs W1C, and edge during its own ack
    irqIn = 32'h8; write = 1'b1; regSel = 3'd0; dataIn = 32'h8; tick();
    write = 1'b0; irqIn = '0;
    rd(3'd0); idle(1);
    irqIn = 32'h8; irqAck = 1'b1; tick(); irqAck = 1'b0; irqIn = '0;
    rd(3'd0); wr(3'd4, 32'd0); idle(2); ack(); wr(3'd4, 32'd0); idle(2);

    // Mask removed while requesting, then restored
    irqIn = 32'h40; tick(); irqIn = '0; idle(2);
    wr(3'd1, 32'h0000_00BF); idle(1); rd(3'd3); rd(3'd0);
    wr(3'd1, 32'h0000_00FF); idle(2);
    ack(); wr(3'd4, 32'd0); idle(2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 799) == 0);
      irqIn  = irqIn ^ ($urandom & $urandom & $urandom & $urandom);
      read   = ($urandom_range(0, 2) == 0);
      write  = ($urandom_range(0, 3) == 0);
      regSel = 3'($urandom_range(0, 7));
      dataIn = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      irqAck = m_cpuirq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      tick();
    end
    reset = 1'b0; read = 1'b0; write = 1'b0; irqAck = 1'b0; irqIn = '0;
    idle(3);

    // 8-source instance
    b_chk("b_rst_cpuIrq", 32'(b_cpuIrq), 32'd0);
    b_chk("b_rst_vec", 32'(b_vec), 32'd0);
    b_chk("b_rst_valid", 32'(b_valid), 32'd0);
    b_reset = 1'b0;
    b_write = 1'b1; b_regSel = 3'd1; b_dataIn = 32'hFFFF_FFFF; tick(); b_write = 1'b0;
    b_rd(3'd1, 32'h0000_00FF, "b_mask");
    b_rd(3'd2, 32'h0000_00FF, "b_mode");
    b_irqIn = 8'h01; tick(); b_irqIn = '0; tick();
    b_chk("b_req_cpuIrq", 32'(b_cpuIrq), 32'd1);
    b_chk("b_req_vec", 32'(b_vec), 32'd0);
    b_irqAck = 1'b1; tick(); b_irqAck = 1'b0;
    b_chk("b_svc_cpuIrq", 32'(b_cpuIrq), 32'd0);
    b_rd(3'd3, 32'h8000_0000, "b_status_svc");
    b_rd(3'd0, 32'h0000_0000, "b_pend_after_ack");
    b_irqIn = 8'h04; tick(); b_irqIn = '0; tick();
    b_rd(3'd0, 32'h0000_0004, "b_pend_in_svc");
    b_reset = 1'b1; tick(); b_reset = 1'b0;
    b_chk("b_mid_rst_cpuIrq", 32'(b_cpuIrq), 32'd0);
    b_chk("b_mid_rst_valid", 32'(b_valid), 32'd0);
    b_rd(3'd0, 32'h0, "b_pend_rst");
    b_rd(3'd1, 32'h0, "b_mask_rst");
    b_rd(3'd2, 32'h0000_00FF, "b_mode_rst");
    b_rd(3'd3, 32'h0, "b_status_rst");
    b_write = 1'b1; b_regSel = 3'd5; b_dataIn = 32'hFFFF_FFFF; tick(); b_write = 1'b0;
    b_rd(3'd5, 32'h0, "b_reserved5");
    b_rd(3'd7, 32'h0, "b_reserved7");

    idle(2);
    checks++;
    if (cyc_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d left expected 0/0", cyc_q.size(), rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
